// File: rtl/cpu_sequencer.sv
// cpu_sequencer: run-control sequencer for a small CPU core.
//   Holds the CPU in reset for RST_CYC cycles, then lets the host single-step
//   it or free-run it at one clock-enable strobe every RATIO cycles.
//
// Parameters
//   RATIO   : cycles between cpu_en strobes in RUN (1 .. 2^24)
//   RST_CYC : cycles cpu_rst is held high in RST (1 .. 255)
//   PC_W    : CPU program counter width
//
// Ports
//   pin_clk   in   clock, rising edge
//   pin_rst   in   asynchronous active-low reset
//   clr       in   pulse, restart the CPU (re-enter RST)
//   start     in   pulse, IDLE -> RUN
//   stop      in   pulse, RUN -> IDLE
//   step      in   pulse, one cpu_en strobe from IDLE
//   cpu_halt  in   level, CPU executed HALT (RUN -> HALTED)
//   cpu_pc    in   CPU program counter
//   bp_addr   in   breakpoint address
//   cpu_en    out  registered one-cycle CPU clock enable
//   cpu_rst   out  registered active-high CPU reset
//   state     out  0 RST, 1 IDLE, 2 RUN, 3 HALTED
//   bp_hit    out  registered one-cycle breakpoint pulse
//
// Configuration
//   CPU_SEQUENCER_BREAKPOINT_EN : when defined, a strobe whose cpu_pc equals
//   bp_addr is replaced by a bp_hit pulse and a return to IDLE. Undefined,
//   bp_addr is ignored and bp_hit is held at 0.
module cpu_sequencer #(
  parameter int RATIO   = 10,
  parameter int RST_CYC = 2,
  parameter int PC_W    = 4
) (
  input  logic            pin_clk,
  input  logic            pin_rst,
  input  logic            clr,
  input  logic            start,
  input  logic            stop,
  input  logic            step,
  input  logic            cpu_halt,
  input  logic [PC_W-1:0] cpu_pc,
  input  logic [PC_W-1:0] bp_addr,
  output logic            cpu_en,
  output logic            cpu_rst,
  output logic [1:0]      state,
  output logic            bp_hit
);

  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(RATIO - 1);
  localparam logic [7:0]       RST_LD  = 8'(RST_CYC - 1);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_IDLE = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } st_t;

  st_t             cur, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       rst_cnt, rst_cnt_nxt;
  logic             first, first_nxt;   // next strobe is the first after start
  logic             en_nxt, bp_nxt;
  logic             tick, bp_match;

  assign tick = (cnt == LAST);

`ifdef CPU_SEQUENCER_BREAKPOINT_EN
  // The first strobe after start skips the compare so a resume from a
  // breakpoint can execute the instruction it stopped on.
  assign bp_match = (cpu_pc == bp_addr) && !first;
`else
  assign bp_match = 1'b0;
  wire unused_bp = ^{cpu_pc, bp_addr};
`endif

  always_comb begin
    nxt         = cur;
    cnt_nxt     = cnt;
    rst_cnt_nxt = rst_cnt;
    first_nxt   = first;
    en_nxt      = 1'b0;
    bp_nxt      = 1'b0;
    if (clr) begin
      nxt         = S_RST;
      rst_cnt_nxt = RST_LD;
      cnt_nxt     = '0;
    end else begin
      unique case (cur)
        S_RST: begin
          if (rst_cnt == 8'd0) nxt = S_IDLE;
          else                 rst_cnt_nxt = rst_cnt - 8'd1;
        end
        S_IDLE: begin
          if (start) begin
            nxt       = S_RUN;
            cnt_nxt   = '0;
            first_nxt = 1'b1;
          end else if (step) begin
            en_nxt = 1'b1;
          end
        end
        S_RUN: begin
          // stop/halt/breakpoint all win over a same-cycle strobe
          if (stop)                 nxt = S_IDLE;
          else if (cpu_halt)        nxt = S_HALT;
          else if (tick && bp_match) begin
            bp_nxt = 1'b1;
            nxt    = S_IDLE;
          end else if (tick) begin
            cnt_nxt   = '0;
            en_nxt    = 1'b1;
            first_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_HALT: ;
        default: nxt = S_RST;
      endcase
    end
  end

  always_ff @(posedge pin_clk or negedge pin_rst) begin
    if (!pin_rst) begin
      cur     <= S_RST;
      cnt     <= '0;
      rst_cnt <= RST_LD;
      first   <= 1'b0;
      cpu_en  <= 1'b0;
      cpu_rst <= 1'b1;
      bp_hit  <= 1'b0;
    end else begin
      cur     <= nxt;
      cnt     <= cnt_nxt;
      rst_cnt <= rst_cnt_nxt;
      first   <= first_nxt;
      cpu_en  <= en_nxt;
      cpu_rst <= (nxt == S_RST);
      bp_hit  <= bp_nxt;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: two instances (RATIO=10/RST_CYC=2 and
// RATIO=1/RST_CYC=1) share stimulus; each is compared every cycle against a
// mode-level reference model, plus directed timing checks.
module tb_cpu_sequencer;

`ifdef CPU_SEQUENCER_BREAKPOINT_EN
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif

  localparam int M_RST = 0, M_IDLE = 1, M_RUN = 2, M_HALT = 3;

  logic       clk = 1'b0;
  logic       pin_rst = 1'b0;
  logic       clr = 0, start = 0, stop = 0, step = 0, cpu_halt = 0;
  logic [3:0] cpu_pc = '0, bp_addr = '0;
  logic       en_a, rst_a, bp_a, en_b, rst_b, bp_b;
  logic [1:0] st_a, st_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.RATIO(10), .RST_CYC(2), .PC_W(4)) dut_a (
    .pin_clk(clk), .pin_rst(pin_rst), .clr(clr), .start(start), .stop(stop),
    .step(step), .cpu_halt(cpu_halt), .cpu_pc(cpu_pc), .bp_addr(bp_addr),
    .cpu_en(en_a), .cpu_rst(rst_a), .state(st_a), .bp_hit(bp_a));

  cpu_sequencer #(.RATIO(1), .RST_CYC(1), .PC_W(4)) dut_b (
    .pin_clk(clk), .pin_rst(pin_rst), .clr(clr), .start(start), .stop(stop),
    .step(step), .cpu_halt(cpu_halt), .cpu_pc(cpu_pc), .bp_addr(bp_addr),
    .cpu_en(en_b), .cpu_rst(rst_b), .state(st_b), .bp_hit(bp_b));

  // Reference model: mode, remaining reset cycles, cycles spent in RUN.
  int m_ratio[2] = '{10, 1};
  int m_rstc[2]  = '{2, 1};
  int m_mode[2], m_rem[2], m_k[2];
  bit m_first[2], m_en[2], m_bp[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_RST; m_rem[i] = m_rstc[i]; m_k[i] = 0;
      m_first[i] = 0; m_en[i] = 0; m_bp[i] = 0;
    end
  endtask

  task automatic model_edge();
    if (!pin_rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      bit due;
      m_en[i] = 0; m_bp[i] = 0;
      due = ((m_k[i] + 1) % m_ratio[i]) == 0;
      if (clr) begin
        m_mode[i] = M_RST; m_rem[i] = m_rstc[i];
      end else if (m_mode[i] == M_RST) begin
        m_rem[i]--;
        if (m_rem[i] == 0) m_mode[i] = M_IDLE;
      end else if (m_mode[i] == M_IDLE) begin
        if (start) begin m_mode[i] = M_RUN; m_k[i] = 0; m_first[i] = 1; end
        else if (step) m_en[i] = 1;
      end else if (m_mode[i] == M_RUN) begin
        if (stop) m_mode[i] = M_IDLE;
        else if (cpu_halt) m_mode[i] = M_HALT;
        else if (due && BP_ON && !m_first[i] && cpu_pc == bp_addr) begin
          m_bp[i] = 1; m_mode[i] = M_IDLE;
        end else begin
          if (due) begin m_en[i] = 1; m_first[i] = 0; end
          m_k[i]++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.state", 32'(st_a), 32'(m_mode[0]));
    chk("a.cpu_en", 32'(en_a), 32'(m_en[0]));
    chk("a.cpu_rst", 32'(rst_a), 32'(m_mode[0] == M_RST));
    chk("a.bp_hit", 32'(bp_a), 32'(m_bp[0]));
    chk("b.state", 32'(st_b), 32'(m_mode[1]));
    chk("b.cpu_en", 32'(en_b), 32'(m_en[1]));
    chk("b.cpu_rst", 32'(rst_b), 32'(m_mode[1] == M_RST));
    chk("b.bp_hit", 32'(bp_b), 32'(m_bp[1]));
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge
  // with the one-cycle pulses cleared.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1 check_all();
    @(negedge clk);
    clr = 0; start = 0; stop = 0; step = 0; cpu_halt = 0;
  endtask

  task automatic async_reset();
    #2 pin_rst = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    cycle();
    pin_rst = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    cycle();
    cycle();
    // Reset release: RST_CYC cycles of cpu_rst, then IDLE
    pin_rst = 1'b1;
    chk("rel.cpu_rst0", 32'(rst_a), 32'd1);
    cycle();
    chk("rel.cpu_rst1", 32'(rst_a), 32'd1);
    cycle();
    chk("rel.idle", 32'(st_a), 32'd1);
    chk("rel.cpu_en", 32'(en_a), 32'd0);

    // RATIO=10 run timing: strobes at T+11, T+21, T+31
    start = 1; cycle();
    for (int n = 1; n <= 39; n++) begin
      cycle();
      if (n <= 30)
        chk("run.en_a", 32'(en_a), 32'(n == 10 || n == 20 || n == 30));
    end
    // counter is now at RATIO-1: stop must eat the strobe
    stop = 1; cycle();
    chk("stop.en_a", 32'(en_a), 32'd0);
    chk("stop.state", 32'(st_a), 32'd1);
    cycle();
    chk("stop.en_after", 32'(en_a), 32'd0);

    // Single steps
    for (int s = 0; s < 3; s++) begin
      step = 1; cycle();
      chk("step.en", 32'(en_a), 32'd1);
      chk("step.state", 32'(st_a), 32'd1);
      for (int j = 0; j < 4; j++) begin
        cycle();
        chk("step.gap", 32'(en_a), 32'd0);
      end
    end

    // Halt, ignored commands, clr recovery
    start = 1; cycle();
    repeat (4) cycle();
    cpu_halt = 1; cycle();
    chk("halt.state", 32'(st_a), 32'd3);
    start = 1; cycle();
    step = 1; cycle();
    stop = 1; cycle();
    repeat (12) cycle();
    chk("halt.hold", 32'(st_a), 32'd3);
    clr = 1; cycle();
    chk("clr.state", 32'(st_a), 32'd0);
    chk("clr.rst0", 32'(rst_a), 32'd1);
    cycle();
    chk("clr.rst1", 32'(rst_a), 32'd1);
    cycle();
    chk("clr.idle", 32'(st_a), 32'd1);
    chk("clr.rst_lo", 32'(rst_a), 32'd0);

`ifdef CPU_SEQUENCER_BREAKPOINT_EN
    bp_addr = 4'd4; cpu_pc = 4'd4;
    start = 1; cycle();
    for (int n = 1; n <= 20; n++) begin
      cycle();
      if (n == 10) chk("bp.first_en", 32'(en_a), 32'd1);
    end
    chk("bp.hit", 32'(bp_a), 32'd1);
    chk("bp.en", 32'(en_a), 32'd0);
    chk("bp.state", 32'(st_a), 32'd1);
    start = 1; cycle();
    for (int n = 1; n <= 10; n++) cycle();
    chk("bp.resume_en", 32'(en_a), 32'd1);
    stop = 1; cycle();
`endif

    // Asynchronous reset in the middle of RUN
    start = 1; cycle();
    repeat (7) cycle();
    async_reset();
    for (int n = 0; n < 12; n++) begin
      cycle();
      if (n >= 2) chk("arst.no_en", 32'(en_a), 32'd0);
    end

    // Randomized traffic, one command per cycle at most
    bp_addr = 4'($urandom_range(0, 7));
    for (int c = 0; c < 600; c++) begin
      int r;
      r = $urandom_range(0, 199);
      cpu_pc = 4'($urandom_range(0, 7));
      if (r == 0) begin
        async_reset();
      end else begin
        if (r < 4)        clr = 1;
        else if (r < 14)  stop = 1;
        else if (r < 18)  cpu_halt = (m_mode[0] == M_RUN && m_mode[1] == M_RUN);
        else if (r < 38)  start = 1;
        else if (r < 58)  step = 1;
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter RATIO, default 10, clock cycles between CPU enable strobes in RUN; legal range 1 to 2^24.
REQ-002 Parameter RST_CYC, default 2, number of cycles cpu_rst is held high; legal range 1 to 255.
REQ-003 Parameter PC_W, default 4, width of the CPU program counter.
REQ-004 pin_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 pin_rst  input  1  asynchronous, active-low reset.
REQ-006 clr  input  1  one-cycle pulse; restart the CPU.
REQ-007 start  input  1  one-cycle pulse; enter free-run.
REQ-008 stop  input  1  one-cycle pulse; leave free-run.
REQ-009 step  input  1  one-cycle pulse; execute one instruction.
REQ-010 cpu_halt  input  1  level; CPU has executed HALT.
REQ-011 cpu_pc  input  PC_W  current CPU program counter.
REQ-012 bp_addr  input  PC_W  breakpoint address.
REQ-013 cpu_en  output  1  registered one-cycle CPU clock-enable strobe.
REQ-014 cpu_rst  output  1  registered synchronous active-high CPU reset.
REQ-015 state  output  2  FSM state: 0 RST, 1 IDLE, 2 RUN, 3 HALTED.
REQ-016 bp_hit  output  1  registered one-cycle breakpoint-hit pulse.

Function
REQ-017 The FSM SHALL have four states: RST, IDLE, RUN and HALTED.
REQ-018 Command precedence in any cycle SHALL be clr > stop > cpu_halt > breakpoint > start > step.
REQ-019 RST: cpu_rst SHALL be high for exactly RST_CYC cycles; the FSM then enters IDLE; cpu_en SHALL stay 0.
REQ-020 clr in any state SHALL enter RST on the next cycle and restart the RST_CYC count.
REQ-021 IDLE + start SHALL enter RUN with prescaler count cnt=0 on the next cycle.
REQ-022 IDLE + step SHALL raise cpu_en for exactly one cycle, on the cycle after the step pulse; the FSM SHALL remain in IDLE.
REQ-023 RUN: cnt SHALL increment every cycle; in the cycle where cnt==RATIO-1, cnt SHALL wrap to 0 and cpu_en SHALL be registered high.
REQ-024 RUN timing: with start at cycle T, the first cpu_en SHALL be at T+RATIO+1, with a period of RATIO cycles thereafter.
REQ-025 RATIO=1 SHALL give cpu_en high on every RUN cycle after the first.
REQ-026 RUN + stop SHALL enter IDLE; no cpu_en SHALL follow, even if the stop coincides with cnt==RATIO-1.
REQ-027 RUN + cpu_halt SHALL enter HALTED, suppressing any same-cycle strobe.
REQ-028 HALTED SHALL ignore start, step and stop; only clr exits it.
REQ-029 start or step while in RUN, and stop while in IDLE, SHALL be ignored.

Reset
REQ-030 While pin_rst is low: state=RST, cnt=0, cpu_en=0, cpu_rst=1, bp_hit=0, and the RST_CYC counter SHALL be reloaded.
REQ-031 Reset assertion mid-RUN SHALL take effect asynchronously, with no further cpu_en.
REQ-032 After pin_rst is released, the RST sequence SHALL run as in REQ-019.

Configuration
REQ-033 The macro CPU_SEQUENCER_BREAKPOINT_EN SHALL control the breakpoint feature.
REQ-034 With the macro defined: in RUN, in a cycle where cnt==RATIO-1 and cpu_pc==bp_addr, cpu_en SHALL be suppressed, bp_hit SHALL pulse for one cycle, and the FSM SHALL enter IDLE.
REQ-035 With the macro defined: the first strobe after any start SHALL ignore the breakpoint compare, so resume-from-breakpoint works; step SHALL never check the breakpoint.
REQ-036 Without the macro: bp_addr SHALL be ignored, bp_hit SHALL be tied to 0, and the port list SHALL be unchanged.

Verification
REQ-037 Reset release with RST_CYC=2 -> cpu_rst high for 2 cycles, then state=1 and cpu_en=0.
REQ-038 RATIO=10, start at cycle T -> cpu_en pulses at T+11, T+21 and T+31, each one cycle wide.
REQ-039 Stop in the same cycle as cnt==9 -> no cpu_en; state=1 on the next cycle.
REQ-040 Three step pulses in IDLE, 5 cycles apart -> exactly three single-cycle cpu_en pulses, each one cycle after its step.
REQ-041 cpu_halt in RUN, then start and step -> state=3 and no cpu_en; clr -> state=0, cpu_rst high for 2 cycles, then state=1.
REQ-042 Macro defined, bp_addr=4, cpu_pc=4 at a tick -> bp_hit pulse, no cpu_en, state=1; start -> next strobe issued despite cpu_pc=4.
